// File: rtl/cm_pkg.sv
// ---------------------------------------------------------------------------
// cm_pkg
// Shared types and helpers for the cm_* arbitration blocks.
//   t_arb_state : FSM states of the round-robin arbiter (IDLE / OFFER / LOCK)
//   t_arb_algo  : weight comparison direction (highest or lowest weight wins)
//   sclog2      : index width for N items, never less than 1
// ---------------------------------------------------------------------------
package cm_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OFFER,
    ARB_LOCK
  } t_arb_state;

  typedef enum logic {
    ARB_MAX,
    ARB_MIN
  } t_arb_algo;

  // Ceiling log2 with a floor of 1, so a 2-entry arbiter still gets a 1-bit index.
  function automatic int sclog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cm_arb_pick.sv
// ---------------------------------------------------------------------------
// cm_arb_pick
// Combinational circular first-one picker: returns the first set bit of
// i_mask at or after i_start, wrapping DCNT-1 -> 0.
// Ports:
//   i_mask   in   DCNT        candidate set
//   i_start  in   IDX_WIDTH   search start index (0 .. DCNT-1)
//   o_found  out  1           any candidate present
//   o_idx    out  IDX_WIDTH   selected index (0 when nothing found)
// ---------------------------------------------------------------------------
module cm_arb_pick #(
  parameter int DCNT      = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [DCNT-1:0]      i_mask,
  input  logic [IDX_WIDTH-1:0] i_start,
  output logic                 o_found,
  output logic [IDX_WIDTH-1:0] o_idx
);

  localparam logic [IDX_WIDTH:0] DCNT_W = (IDX_WIDTH+1)'(DCNT);

  always_comb begin
    logic [IDX_WIDTH:0]   v_sum;
    logic [IDX_WIDTH-1:0] v_idx;
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < DCNT; k++) begin
      // Start + offset stays below 2*DCNT, so one conditional subtract wraps it.
      v_sum = {1'b0, i_start} + (IDX_WIDTH+1)'(k);
      if (v_sum >= DCNT_W) v_sum = v_sum - DCNT_W;
      v_idx = v_sum[IDX_WIDTH-1:0];
      if (!o_found && i_mask[v_idx]) begin
        o_found = 1'b1;
        o_idx   = v_idx;
      end
    end
  end

endmodule

// File: rtl/cm_arbiter_rr.sv
// ---------------------------------------------------------------------------
// cm_arbiter_rr
// Weighted arbiter with round-robin tie-break, starvation aging, a valid/ready
// grant handshake and an optional grant lock for multi-beat transfers.
// One registered grant offer per cycle.
// Ports:
//   i_clk     in   1                clock
//   i_rst     in   1                asynchronous active-high reset
//   i_req     in   DCNT             request vector
//   i_weight  in   DCNT*DWIDTH      per-requester weights, ch i at [i*DWIDTH +: DWIDTH]
//   i_rdy     in   1                consumer accepts the offered grant
//   i_lock    in   1                sampled at accept; holds the grant while high
//   o_vld     out  1                grant offer valid
//   o_gnt     out  IDX_WIDTH        granted index
//   o_gnt_oh  out  DCNT             one-hot of o_gnt (zero when idle)
//   o_lock    out  1                arbiter is in LOCK state
// ---------------------------------------------------------------------------
module cm_arbiter_rr
  import cm_pkg::*;
#(
  parameter int        DCNT      = 4,
  parameter int        DWIDTH    = 8,
  parameter t_arb_algo ALGO      = ARB_MAX,
  parameter int        AGE_WIDTH = 4,
  parameter int        AGE_LIMIT = 15,
  parameter int        LOCK_EN   = 1,
  localparam int       IDX_WIDTH = sclog2(DCNT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DCNT-1:0]        i_req,
  input  logic [DCNT*DWIDTH-1:0] i_weight,
  input  logic                   i_rdy,
  input  logic                   i_lock,
  output logic                   o_vld,
  output logic [IDX_WIDTH-1:0]   o_gnt,
  output logic [DCNT-1:0]        o_gnt_oh,
  output logic                   o_lock
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX  = AGE_WIDTH'(AGE_LIMIT);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DCNT - 1);

  t_arb_state           r_state;
  logic                 r_vld;
  logic                 r_lock;
  logic [IDX_WIDTH-1:0] r_gnt;
  logic [DCNT-1:0]      r_gnt_oh;
  logic [IDX_WIDTH-1:0] r_ptr;
  logic [AGE_WIDTH-1:0] r_age [DCNT];

  logic                 w_hs;
  logic [IDX_WIDTH-1:0] w_ptr_nxt;
  logic [AGE_WIDTH-1:0] w_age_nxt [DCNT];
  logic [DWIDTH-1:0]    w_best;
  logic [DCNT-1:0]      w_starve;
  logic [DCNT-1:0]      w_best_mask;
  logic [DCNT-1:0]      w_mask;
  logic                 w_found;
  logic [IDX_WIDTH-1:0] w_pick;
  logic [DCNT-1:0]      w_pick_oh;

  assign w_hs = r_vld & i_rdy;

  // Pointer and ages as they will be after this cycle; a back-to-back decision
  // in an accept cycle must already see the effect of that accept.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_hs) w_ptr_nxt = (r_gnt == LAST_IDX) ? '0 : r_gnt + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < DCNT; i++) begin
      w_age_nxt[i] = r_age[i];
      if (!i_req[i]) begin
        w_age_nxt[i] = '0;
      end else if (w_hs) begin
        if (r_gnt == IDX_WIDTH'(i))  w_age_nxt[i] = '0;
        else if (r_age[i] < AGE_MAX) w_age_nxt[i] = r_age[i] + 1'b1;
      end
    end
  end

  // Best weight among requesters, then the candidate mask. Starving requesters
  // override weights entirely.
  always_comb begin
    w_best = (ALGO == ARB_MAX) ? '0 : '1;
    for (int i = 0; i < DCNT; i++) begin
      if (i_req[i]) begin
        if ((ALGO == ARB_MAX) && (i_weight[i*DWIDTH +: DWIDTH] > w_best))
          w_best = i_weight[i*DWIDTH +: DWIDTH];
        if ((ALGO == ARB_MIN) && (i_weight[i*DWIDTH +: DWIDTH] < w_best))
          w_best = i_weight[i*DWIDTH +: DWIDTH];
      end
    end
    for (int i = 0; i < DCNT; i++) begin
      w_starve[i]    = i_req[i] && (w_age_nxt[i] == AGE_MAX);
      w_best_mask[i] = i_req[i] && (i_weight[i*DWIDTH +: DWIDTH] == w_best);
    end
    w_mask = (|w_starve) ? w_starve : w_best_mask;
  end

  cm_arb_pick #(
    .DCNT      (DCNT),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .i_mask  (w_mask),
    .i_start (w_ptr_nxt),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_comb begin
    for (int i = 0; i < DCNT; i++) w_pick_oh[i] = (w_pick == IDX_WIDTH'(i));
  end

  // NOTE: the age array is reset explicitly; starvation priority depends on it,
  // so it must not start from arbitrary values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DCNT; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < DCNT; i++) r_age[i] <= w_age_nxt[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ARB_IDLE;
      r_vld    <= 1'b0;
      r_lock   <= 1'b0;
      r_gnt    <= '0;
      r_gnt_oh <= '0;
      r_ptr    <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state  <= ARB_OFFER;
            r_vld    <= 1'b1;
            r_gnt    <= w_pick;
            r_gnt_oh <= w_pick_oh;
          end
        end
        ARB_OFFER: begin
          // Offer is frozen until accepted, even if the request goes away.
          if (i_rdy) begin
            if (i_lock && (LOCK_EN != 0)) begin
              r_state <= ARB_LOCK;
              r_vld   <= 1'b0;
              r_lock  <= 1'b1;
            end else if (w_found) begin
              r_gnt    <= w_pick;
              r_gnt_oh <= w_pick_oh;
            end else begin
              r_state  <= ARB_IDLE;
              r_vld    <= 1'b0;
              r_gnt_oh <= '0;
            end
          end
        end
        ARB_LOCK: begin
          if (!i_lock) begin
            r_state  <= ARB_IDLE;
            r_lock   <= 1'b0;
            r_gnt_oh <= '0;
          end
        end
        default: begin
          r_state  <= ARB_IDLE;
          r_vld    <= 1'b0;
          r_lock   <= 1'b0;
          r_gnt_oh <= '0;
        end
      endcase
    end
  end

  assign o_vld    = r_vld;
  assign o_gnt    = r_gnt;
  assign o_gnt_oh = r_gnt_oh;
  assign o_lock   = r_lock;

endmodule

// File: tb/tb_cm_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_cm_arbiter_rr
// Directed bench for cm_arbiter_rr. Four instances share clock and reset:
//   u_dut    DCNT=4, ARB_MAX, AGE_LIMIT=15, LOCK_EN=1
//   u_age    DCNT=4, ARB_MAX, AGE_LIMIT=3
//   u_nolock DCNT=4, ARB_MAX, LOCK_EN=0
//   u_min    DCNT=5, ARB_MIN
// The three 4-channel instances see the same stimulus; each step only checks
// the instance it targets. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_cm_arbiter_rr;
  import cm_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  req;
  logic [31:0] weight;
  logic        rdy;
  logic        lock;
  logic [4:0]  m_req;
  logic [39:0] m_weight;
  logic        m_rdy;
  logic        m_lock;

  logic       d_vld, d_lock, a_vld, a_lock, n_vld, n_lock, m_vld, m_olock;
  logic [1:0] d_gnt, a_gnt, n_gnt;
  logic [3:0] d_oh, a_oh, n_oh;
  logic [2:0] m_gnt;
  logic [4:0] m_oh;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_max [6] = '{1, 2, 1, 2, 1, 2};
  int exp_age [8] = '{3, 3, 3, 0, 3, 3, 3, 0};
  int exp_min [7] = '{0, 1, 2, 3, 4, 0, 1};
  int exp_minw[3] = '{1, 3, 1};

  always #5 i_clk = ~i_clk;

  cm_arbiter_rr #(.DCNT(4), .DWIDTH(8), .ALGO(ARB_MAX), .AGE_WIDTH(4), .AGE_LIMIT(15), .LOCK_EN(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(req), .i_weight(weight), .i_rdy(rdy), .i_lock(lock),
    .o_vld(d_vld), .o_gnt(d_gnt), .o_gnt_oh(d_oh), .o_lock(d_lock));

  cm_arbiter_rr #(.DCNT(4), .DWIDTH(8), .ALGO(ARB_MAX), .AGE_WIDTH(4), .AGE_LIMIT(3), .LOCK_EN(1)) u_age (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(req), .i_weight(weight), .i_rdy(rdy), .i_lock(lock),
    .o_vld(a_vld), .o_gnt(a_gnt), .o_gnt_oh(a_oh), .o_lock(a_lock));

  cm_arbiter_rr #(.DCNT(4), .DWIDTH(8), .ALGO(ARB_MAX), .AGE_WIDTH(4), .AGE_LIMIT(15), .LOCK_EN(0)) u_nolock (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(req), .i_weight(weight), .i_rdy(rdy), .i_lock(lock),
    .o_vld(n_vld), .o_gnt(n_gnt), .o_gnt_oh(n_oh), .o_lock(n_lock));

  cm_arbiter_rr #(.DCNT(5), .DWIDTH(8), .ALGO(ARB_MIN), .AGE_WIDTH(4), .AGE_LIMIT(15), .LOCK_EN(1)) u_min (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(m_req), .i_weight(m_weight), .i_rdy(m_rdy), .i_lock(m_lock),
    .o_vld(m_vld), .o_gnt(m_gnt), .o_gnt_oh(m_oh), .o_lock(m_olock));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst    = 1'b1;
    req      = '0;
    weight   = '0;
    rdy      = 1'b0;
    lock     = 1'b0;
    m_req    = '0;
    m_weight = '0;
    m_rdy    = 1'b0;
    m_lock   = 1'b0;

    // Reset state
    #1;
    check("rst_vld",  32'(d_vld),  32'd0);
    check("rst_gnt",  32'(d_gnt),  32'd0);
    check("rst_oh",   32'(d_oh),   32'd0);
    check("rst_lock", 32'(d_lock), 32'd0);
    tick();
    tick();
    i_rst = 1'b0;

    // ARB_MAX, w = {ch3:10, ch2:40, ch1:40, ch0:5}: ch1/ch2 alternate
    weight = {8'd10, 8'd40, 8'd40, 8'd5};
    req    = 4'hF;
    rdy    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("max_vld", 32'(d_vld), 32'd1);
      check("max_gnt", 32'(d_gnt), 32'(exp_max[k]));
      check("max_oh",  32'(d_oh),  32'(1 << exp_max[k]));
    end

    // Reset while offering ch2: outputs drop immediately
    rdy   = 1'b0;
    i_rst = 1'b1;
    #1;
    check("midrst_vld", 32'(d_vld), 32'd0);
    check("midrst_gnt", 32'(d_gnt), 32'd0);
    check("midrst_oh",  32'(d_oh),  32'd0);
    weight = 32'h09090909;
    #1;
    i_rst = 1'b0;
    tick();
    check("postrst_vld", 32'(d_vld), 32'd1);
    check("postrst_gnt", 32'(d_gnt), 32'd0);

    // Backpressure: offer ch1 frozen while its weight and request drop
    pulse_reset();
    weight = {8'd10, 8'd40, 8'd40, 8'd5};
    req    = 4'hF;
    rdy    = 1'b0;
    tick();
    check("bp_first_gnt", 32'(d_gnt), 32'd1);
    weight = {8'd10, 8'd40, 8'd0, 8'd5};
    req    = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_vld", 32'(d_vld), 32'd1);
      check("bp_gnt", 32'(d_gnt), 32'd1);
      check("bp_oh",  32'(d_oh),  32'b0010);
    end
    rdy = 1'b1;
    tick();
    check("bp_next_vld", 32'(d_vld), 32'd1);
    check("bp_next_gnt", 32'(d_gnt), 32'd2);
    rdy = 1'b0;

    // Aging with AGE_LIMIT=3: ch0 (w=1) competes with ch3 (w=200)
    pulse_reset();
    weight = {8'd200, 8'd0, 8'd0, 8'd1};
    req    = 4'b1001;
    rdy    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("age_vld", 32'(a_vld), 32'd1);
      check("age_gnt", 32'(a_gnt), 32'(exp_age[k]));
      if (k == 3) check("age_ch0_before", 32'(u_age.r_age[0]), 32'd3);
      if (k == 4) check("age_ch0_after",  32'(u_age.r_age[0]), 32'd0);
    end
    rdy = 1'b0;

    // Lock: accept ch2 with i_lock held for 4 cycles
    pulse_reset();
    weight = 32'h0;
    req    = 4'b0100;
    rdy    = 1'b0;
    lock   = 1'b0;
    tick();
    check("lk_offer_vld", 32'(d_vld), 32'd1);
    check("lk_offer_gnt", 32'(d_gnt), 32'd2);
    rdy  = 1'b1;
    lock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("lk_lock",    32'(d_lock), 32'd1);
      check("lk_vld",     32'(d_vld),  32'd0);
      check("lk_gnt",     32'(d_gnt),  32'd2);
      check("lk_oh",      32'(d_oh),   32'b0100);
      check("nolk_lock",  32'(n_lock), 32'd0);
      check("nolk_vld",   32'(n_vld),  32'd1);
    end
    lock = 1'b0;
    tick();
    check("lk_rel_lock", 32'(d_lock), 32'd0);
    check("lk_rel_vld",  32'(d_vld),  32'd0);
    check("lk_rel_oh",   32'(d_oh),   32'd0);
    tick();
    check("lk_again_vld", 32'(d_vld), 32'd1);
    check("lk_again_gnt", 32'(d_gnt), 32'd2);
    rdy = 1'b0;
    req = '0;

    // ARB_MIN, DCNT=5, equal weights: pure round robin with 4->0 wrap
    pulse_reset();
    m_weight = 40'h0707070707;
    m_req    = 5'h1F;
    m_rdy    = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("min_vld", 32'(m_vld), 32'd1);
      check("min_gnt", 32'(m_gnt), 32'(exp_min[k]));
      check("min_oh",  32'(m_oh),  32'(1 << exp_min[k]));
    end

    // ARB_MIN, w = {ch4:8, ch3:3, ch2:5, ch1:3, ch0:9}: ch1/ch3 alternate
    pulse_reset();
    m_weight = {8'd8, 8'd3, 8'd5, 8'd3, 8'd9};
    for (int k = 0; k < 3; k++) begin
      tick();
      check("minw_gnt", 32'(m_gnt), 32'(exp_minw[k]));
    end
    m_rdy = 1'b0;
    m_req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
